uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NREQ  4    number of requesters
  DW    8    data width per frame
  TMO   64   clk cycles allowed for tx_busy to rise after tx_start
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk        in   1        clock, rising edge
  rst        in   1        reset, asynchronous, active-low
  req_valid  in   NREQ     per-requester frame request
  req_data   in   NREQ*DW  requester i data at bits [i*DW +: DW]
  req_ready  out  NREQ     one-hot one-cycle accept pulse
  tx_data    out  DW       frame data to the UART TX datapath
  tx_start   out  1        one-cycle frame start pulse to TX
  tx_busy    in   1        TX frame in progress
  tx_done    in   1        one-cycle TX end-of-frame pulse
  grant_id   out  clog2(NREQ)  index of current or last granted requester
  active     out  1        arbiter owns TX (state not IDLE)
  tmo_err    out  1        one-cycle pulse on busy timeout

Function
REQ-003 FSM states SHALL be IDLE, GRANT, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-004 IDLE: if any req_valid high, the block SHALL pick winner by round-robin starting at (last_grant+1) mod NREQ, latch req_data of winner into tx_data, set grant_id, go to GRANT.
REQ-005 GRANT (exactly one cycle): tx_start=1, req_ready[grant_id]=1, all other req_ready=0; next state WAIT_BUSY.
REQ-006 Latency SHALL be one cycle: req_valid sampled high in IDLE -> tx_start and req_ready high on the next cycle.
REQ-007 WAIT_BUSY: tx_busy high -> WAIT_DONE; else count cycles; count reaching TMO -> tmo_err pulse, go to IDLE.
REQ-008 WAIT_DONE: tx_done high -> IDLE; no timeout in this state.
REQ-009 tx_data SHALL stay stable from GRANT until return to IDLE.
REQ-010 last_grant SHALL update to grant_id on leaving GRANT, so the winner has lowest priority next round even after a timeout.
REQ-011 Requester SHALL hold req_valid/req_data until req_ready; req_valid dropping before grant SHALL cause no grant.
REQ-012 req_valid changes outside IDLE SHALL be ignored; no preemption of an owned frame.
REQ-013 tx_done or tx_busy seen in IDLE SHALL be ignored.
REQ-014 tx_done in WAIT_DONE with req_valid high: return to IDLE that cycle, arbitrate next cycle (one idle cycle minimum between frames).
REQ-015 Timeout counter SHALL clear on entering WAIT_BUSY; width clog2(TMO+1); no wrap.
REQ-016 Single requester continuously valid SHALL be regranted back-to-back every frame.

Reset
REQ-017 rst low SHALL force, asynchronously: state IDLE, tx_start=0, req_ready=0, tmo_err=0, active=0, tx_data=0, grant_id=0, counter=0, last_grant=NREQ-1 (requester 0 highest priority).
REQ-018 Reset mid-frame SHALL abort without further tx_start; first grant after release follows REQ-017 priority.

Structure
REQ-019 State encoding and default NREQ/DW/TMO SHALL live in shared package uart_pkg.
REQ-020 Round-robin winner selection SHALL be sub-module rr_arbiter (inputs req vector, last_grant; outputs any, winner index).

Verification
REQ-021 Single request: req_valid=0001, data[0]=0xA5, TX busy 2 cycles later, done 10 cycles later -> tx_start and req_ready=0001 one cycle after valid, tx_data=0xA5 until IDLE.
REQ-022 All four requesting continuously after reset -> grant order 0,1,2,3,0; each req_ready one-hot, one per frame.
REQ-023 Request 1 and 3 with last_grant=1 -> grant 3 first, then 1.
REQ-024 tx_busy never rises, TMO=64 -> tmo_err pulse 64 cycles after entering WAIT_BUSY, state IDLE, next grant skips timed-out requester if others valid.
REQ-025 rst low during WAIT_DONE -> all outputs zero immediately; after release with req_valid=1111 -> requester 0 granted.
REQ-026 tx_done pulse while IDLE and req_valid toggling during WAIT_DONE -> no state change, no extra req_ready.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: default sizing and the
// arbiter state encoding.
package uart_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 8;
    localparam int TMO_DEF  = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Round-robin winner selection. The search starts just after last_grant, so
// the most recently served requester has the lowest priority.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic            any,
    output logic [IW-1:0]   winner
);

    // Scan from the farthest candidate to the nearest so that the nearest
    // requester after last_grant overrides any earlier match.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int k = NREQ; k >= 1; k--) begin
            logic [IW-1:0] idx;
            idx = IW'((int'(last_grant) + k) % NREQ);
            if (req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates several frame requesters onto one UART TX datapath.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | TX free; arbitrate among valid requesters
// ST_GRANT     | one-cycle tx_start and req_ready pulse to the winner
// ST_WAIT_BUSY | waiting for TX to raise tx_busy; times out after TMO cycles
// ST_WAIT_DONE | frame in flight; waiting for tx_done
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int TMO  = TMO_DEF,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW  = $clog2(TMO + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [DW-1:0]     tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic [IW-1:0]     grant_id,
    output logic              active,
    output logic              tmo_err
);

    // The counter value seen in the last WAIT_BUSY cycle before timing out.
    localparam logic [CW-1:0] TMO_LAST  = CW'(TMO - 1);
    // Reset so that requester 0 is the first to be considered.
    localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

    arb_state_t    state;
    logic [IW-1:0] last_grant;
    logic [CW-1:0] tmo_cnt;
    logic          arb_any;
    logic [IW-1:0] arb_winner;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant),
        .any        (arb_any),
        .winner     (arb_winner)
    );

    // Arbiter FSM; every output is a register so TX sees clean pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            tx_start   <= 1'b0;
            req_ready  <= '0;
            tmo_err    <= 1'b0;
            active     <= 1'b0;
            tx_data    <= '0;
            grant_id   <= '0;
            tmo_cnt    <= '0;
            last_grant <= LAST_INIT;
        end else begin
            tx_start  <= 1'b0;
            req_ready <= '0;
            tmo_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        state     <= ST_GRANT;
                        grant_id  <= arb_winner;
                        tx_data   <= req_data[arb_winner*DW +: DW];
                        tx_start  <= 1'b1;
                        req_ready <= NREQ'(1) << arb_winner;
                        active    <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // Winner drops to lowest priority even if TX never answers.
                    last_grant <= grant_id;
                    tmo_cnt    <= '0;
                    state      <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        tmo_err <= 1'b1;
                        active  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        active <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    active <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: requester queues and a TX responder drive the DUT;
// a reference model predicts the grant sequence into a scoreboard that an
// independent monitor drains on every accept pulse.
module tb_uart_tx_arb;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TMO  = 64;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [DW-1:0]     tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              tx_done;
    logic [IW-1:0]     grant_id;
    logic              active;
    logic              tmo_err;

    uart_tx_arb #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .grant_id  (grant_id),
        .active    (active),
        .tmo_err   (tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] rq[NREQ][$];
    int            n_pass  = 0;
    int            n_total = 0;
    int            m_last;
    int            rs;
    int            wcnt, dcnt, tcnt;
    bit            hang_mode, force_tmo, rand_tmo, glitch_en;
    logic [NREQ-1:0] glitch;
    logic [DW-1:0] cur_data;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic logic [NREQ-1:0] pending_mask();
        logic [NREQ-1:0] m;
        for (int i = 0; i < NREQ; i++) m[i] = (rq[i].size() != 0);
        return m;
    endfunction

    // Next in the circular order after the last served requester wins.
    function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (m[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // Predict the full service order of everything currently queued.
    function automatic void model_round();
        logic [DW-1:0]   mq[NREQ][$];
        logic [NREQ-1:0] m;
        exp_t            e;
        for (int i = 0; i < NREQ; i++) mq[i] = rq[i];
        forever begin
            for (int i = 0; i < NREQ; i++) m[i] = (mq[i].size() != 0);
            if (m == '0) break;
            e.id   = rr_pick(m, m_last);
            e.data = mq[e.id].pop_front();
            exp_q.push_back(e);
            m_last = e.id;
        end
    endfunction

    function automatic void drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (rq[i].size() != 0) | glitch[i];
            req_data[i*DW +: DW] = (rq[i].size() != 0) ? rq[i][0] : '0;
        end
    endfunction

    // One bench cycle: requesters react to accepts, TX responder advances.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        case (rs)
            0: if (tx_start) begin
                if (hang_mode) begin
                    tx_busy = 1'b1;
                    rs = 4;
                end else if (force_tmo || (rand_tmo && $urandom_range(5) == 0)) begin
                    force_tmo = 1'b0;
                    tcnt = 0;
                    rs = 3;
                end else begin
                    wcnt = $urandom_range(3);
                    dcnt = 2 + $urandom_range(9);
                    if (wcnt == 0) begin
                        tx_busy = 1'b1;
                        rs = 2;
                    end else rs = 1;
                end
            end
            1: begin
                wcnt--;
                if (wcnt == 0) begin
                    tx_busy = 1'b1;
                    rs = 2;
                end
            end
            2: begin
                dcnt--;
                if (dcnt == 0) begin
                    tx_busy = 1'b0;
                    tx_done = 1'b1;
                    glitch  = '0;
                    rs = 5;
                end else if (glitch_en) begin
                    glitch = NREQ'($urandom) & ~pending_mask();
                end
            end
            3: begin
                tcnt++;
                if (tcnt == TMO) chk("tmo_not_early", tmo_err, 0);
                else if (tcnt == TMO + 1) begin
                    chk("tmo_pulse", tmo_err, 1);
                    chk("tmo_idle", active, 0);
                    rs = 0;
                end
            end
            5: begin
                tx_done = 1'b0;
                rs = 0;
            end
            default: ;
        endcase
        drive_reqs();
    endtask

    // Issue everything queued, then wait for the arbiter to drain it.
    task automatic run_round();
        bit done_ok;
        model_round();
        drive_reqs();
        step();
        chk("latency_tx_start", tx_start, 1);
        done_ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (exp_q.size() == 0 && rs == 0 && !active && pending_mask() == '0) begin
                done_ok = 1'b1;
                break;
            end
        end
        if (!done_ok) chk("round_completes", 0, 1);
        step();
    endtask

    // Scoreboard monitor: every accept pulse must match the next prediction.
    always @(negedge clk) begin
        if (rst) begin
            if (tx_start || req_ready != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", {28'd0, req_ready}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("tx_start", tx_start, 1);
                    chk("req_ready", req_ready, 32'd1 << e.id);
                    chk("grant_id", grant_id, e.id);
                    chk("tx_data", tx_data, e.data);
                    chk("active_on_grant", active, 1);
                    cur_data = e.data;
                end
            end else if (active) begin
                chk("tx_data_hold", tx_data, cur_data);
            end
        end
    end

    // Hard stop in case something wedges the stimulus entirely.
    initial begin
        #900_000;
        $display("FAIL watchdog: got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        req_valid = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        glitch    = '0;
        rs        = 0;
        hang_mode = 1'b0;
        force_tmo = 1'b0;
        rand_tmo  = 1'b0;
        glitch_en = 1'b0;
        cur_data  = '0;
        m_last    = NREQ - 1;

        #12;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_tmo_err", tmo_err, 0);
        chk("rst_active", active, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant_id", grant_id, 0);
        step();
        rst = 1'b1;
        step();

        // Single requester, data 0xA5.
        rq[0].push_back(8'hA5);
        run_round();

        // TX handshakes while idle must not start anything.
        tx_done = 1'b1;
        tx_busy = 1'b1;
        step();
        chk("idle_done_active", active, 0);
        tx_done = 1'b0;
        tx_busy = 1'b0;
        step();
        chk("idle_done_ready", req_ready, 0);
        chk("idle_done_active2", active, 0);

        // Serve 1 so it becomes last; then 1 and 3 pending must give 3 first.
        rq[1].push_back(8'h11);
        run_round();
        rq[1].push_back(8'h22);
        rq[3].push_back(8'h33);
        run_round();

        // Lone requester regranted back-to-back; stray valids during frames.
        glitch_en = 1'b1;
        for (int k = 0; k < 3; k++) rq[2].push_back(DW'(8'hC0 + k));
        run_round();
        glitch_en = 1'b0;

        // First frame times out; the timed-out requester then yields.
        force_tmo = 1'b1;
        rq[1].push_back(8'h61);
        rq[1].push_back(8'h62);
        rq[2].push_back(8'h63);
        run_round();

        // Reset while a frame is in flight, then all four requesting.
        hang_mode = 1'b1;
        rq[2].push_back(8'h5A);
        model_round();
        drive_reqs();
        step();
        chk("hang_latency", tx_start, 1);
        reached = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (rs == 4) begin
                reached = 1'b1;
                break;
            end
            step();
        end
        if (!reached) chk("hang_reached", 0, 1);
        for (int c = 0; c < 4; c++) step();
        chk("hang_active", active, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_tmo_err", tmo_err, 0);
        chk("midrst_active", active, 0);
        chk("midrst_tx_data", tx_data, 0);
        chk("midrst_grant_id", grant_id, 0);
        hang_mode = 1'b0;
        rs        = 0;
        tx_busy   = 1'b0;
        glitch    = '0;
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        exp_q.delete();
        m_last = NREQ - 1;
        drive_reqs();
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            rq[i].push_back(DW'(8'h80 + i));
            rq[i].push_back(DW'(8'h90 + i));
        end
        run_round();

        // Randomized rounds with occasional timeouts and stray valids.
        rand_tmo  = 1'b1;
        glitch_en = 1'b1;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                int n;
                n = $urandom_range(3);
                for (int k = 0; k < n; k++) rq[i].push_back(DW'($urandom));
            end
            if (pending_mask() == '0) rq[$urandom_range(NREQ - 1)].push_back(DW'($urandom));
            run_round();
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
